// File: rtl/voice_command_confirm.sv
// Debounces recognised voice commands: a code must repeat CONFIRM_COUNT times within a gap
// window before it is offered on a valid/ack handshake and held as a timed level.
module voice_command_confirm #(
    parameter int unsigned CONFIRM_COUNT = 2,
    parameter int unsigned WINDOW_CYCLES = 27000000,
    parameter int unsigned HOLD_CYCLES   = 54000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       training_enable,
    input  logic [3:0] command,
    input  logic       cmd_ack,
    output logic [3:0] cmd_out,
    output logic       cmd_valid,
    output logic [3:0] active_cmd,
    output logic [7:0] overrun_count,
    output logic [7:0] reject_count
);

    localparam logic [CNT_W-1:0] WinLast  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       HitsNeed = 4'(CONFIRM_COUNT);

    typedef enum logic [1:0] {StIdle, StCand, StPresent} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       hits_q, hits_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       cmd_out_q, cmd_out_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [3:0]       active_q, active_d;
    logic [7:0]       overrun_q, overrun_d;
    logic [7:0]       reject_q, reject_d;

    logic code_valid;
    logic confirm;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        hits_d      = hits_q;
        win_d       = win_q;
        hold_d      = hold_q;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = cmd_valid_q;
        active_d    = active_q;
        overrun_d   = overrun_q;
        reject_d    = reject_q;
        confirm     = 1'b0;
        code_valid  = (command >= 4'd4) && (command <= 4'd11);

        if (active_q != 4'd0) begin
            if (hold_q == HoldLast) begin
                active_d = 4'd0;
                hold_d   = '0;
            end else begin
                hold_d = hold_q + CNT_W'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (code_valid) begin
                    if (CONFIRM_COUNT == 1) begin
                        confirm = 1'b1;
                    end else begin
                        cand_d  = command;
                        hits_d  = 4'd1;
                        win_d   = '0;
                        state_d = StCand;
                    end
                end
            end
            StCand: begin
                win_d = win_q + CNT_W'(1);
                // A match on the timeout cycle still counts, so it is tested first.
                if (code_valid && command == cand_q) begin
                    if (hits_q + 4'd1 == HitsNeed) begin
                        confirm = 1'b1;
                    end else begin
                        hits_d = hits_q + 4'd1;
                        win_d  = '0;
                    end
                end else if (code_valid) begin
                    cand_d = command;
                    hits_d = 4'd1;
                    win_d  = '0;
                end else if (win_q == WinLast) begin
                    state_d  = StIdle;
                    cand_d   = 4'd0;
                    hits_d   = 4'd0;
                    win_d    = '0;
                    reject_d = (reject_q != 8'hFF) ? reject_q + 8'd1 : reject_q;
                end
            end
            StPresent: begin
                if (code_valid) begin
                    overrun_d = (overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;
                end
                if (cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (confirm) begin
            state_d     = StPresent;
            cmd_out_d   = command;
            cmd_valid_d = 1'b1;
            active_d    = command;
            hold_d      = '0;
            cand_d      = 4'd0;
            hits_d      = 4'd0;
            win_d       = '0;
        end

        if (training_enable) begin
            state_d     = StIdle;
            cmd_out_d   = cmd_out_q;
            cmd_valid_d = 1'b0;
            active_d    = 4'd0;
            cand_d      = 4'd0;
            hits_d      = 4'd0;
            win_d       = '0;
            hold_d      = '0;
            overrun_d   = overrun_q;
            reject_d    = reject_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            hits_q      <= 4'd0;
            win_q       <= '0;
            hold_q      <= '0;
            cmd_out_q   <= 4'd0;
            cmd_valid_q <= 1'b0;
            active_q    <= 4'd0;
            overrun_q   <= 8'd0;
            reject_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            hits_q      <= hits_d;
            win_q       <= win_d;
            hold_q      <= hold_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            active_q    <= active_d;
            overrun_q   <= overrun_d;
            reject_q    <= reject_d;
        end
    end

    assign cmd_out       = cmd_out_q;
    assign cmd_valid     = cmd_valid_q;
    assign active_cmd    = active_q;
    assign overrun_count = overrun_q;
    assign reject_count  = reject_q;

endmodule

// File: tb/tb_voice_command_confirm.sv
// Bench for voice_command_confirm: fixed vector table, directed corner sequences and a random
// run, all scored against a timestamp-based reference model.
module tb_voice_command_confirm;

    localparam int CC   = 2;
    localparam int WIN  = 10;
    localparam int HOLD = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       training_enable = 1'b0;
    logic [3:0] command = 4'd0;
    logic       cmd_ack = 1'b0;
    logic [3:0] cmd_out;
    logic       cmd_valid;
    logic [3:0] active_cmd;
    logic [7:0] overrun_count;
    logic [7:0] reject_count;

    voice_command_confirm #(
        .CONFIRM_COUNT(CC),
        .WINDOW_CYCLES(WIN),
        .HOLD_CYCLES  (HOLD),
        .CNT_W        (26)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .training_enable(training_enable),
        .command        (command),
        .cmd_ack        (cmd_ack),
        .cmd_out        (cmd_out),
        .cmd_valid      (cmd_valid),
        .active_cmd     (active_cmd),
        .overrun_count  (overrun_count),
        .reject_count   (reject_count)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model: candidate tracked by the cycle of its last hit, active level by the
    // first cycle it became visible.
    int         n = 0;
    bit         m_pend, m_cand_on;
    logic [3:0] m_out, m_cand, m_active;
    int         m_hits, m_last, m_since, m_ovr, m_rej;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, n);
        else passed++;
    endtask

    task automatic model_edge(input logic rst, input logic tr, input logic [3:0] cmd,
                              input logic ack);
        bit v;
        bit conf;
        v    = (cmd >= 4'd4) && (cmd <= 4'd11);
        conf = 1'b0;
        if (!rst) begin
            m_pend = 0; m_cand_on = 0; m_out = 0; m_cand = 0; m_active = 0;
            m_hits = 0; m_last = 0; m_since = 0; m_ovr = 0; m_rej = 0;
        end else if (tr) begin
            m_pend = 0; m_cand_on = 0; m_active = 0;
        end else begin
            if (m_pend) begin
                if (v && m_ovr < 255) m_ovr++;
                if (ack) m_pend = 0;
            end else if (m_cand_on) begin
                if (v && cmd == m_cand) begin
                    m_hits++;
                    if (m_hits == CC) conf = 1;
                    else m_last = n;
                end else if (v) begin
                    m_cand = cmd; m_hits = 1; m_last = n;
                end else if (n - m_last == WIN) begin
                    m_cand_on = 0;
                    if (m_rej < 255) m_rej++;
                end
            end else if (v) begin
                if (CC == 1) conf = 1;
                else begin
                    m_cand_on = 1; m_cand = cmd; m_hits = 1; m_last = n;
                end
            end
            if (conf) begin
                m_pend = 1; m_cand_on = 0; m_out = cmd; m_active = cmd; m_since = n + 1;
            end else if (m_active != 0 && n - m_since == HOLD - 1) begin
                m_active = 0;
            end
        end
        n++;
    endtask

    task automatic step(input logic rst, input logic tr, input logic [3:0] cmd, input logic ack);
        reset = rst; training_enable = tr; command = cmd; cmd_ack = ack;
        @(posedge clock);
        model_edge(rst, tr, cmd, ack);
        #1;
        check("model", {7'd0, cmd_out, cmd_valid, active_cmd, overrun_count, reject_count},
              {7'd0, m_out, m_pend, m_active, m_ovr[7:0], m_rej[7:0]});
    endtask

    typedef struct {
        logic [3:0] cmd;
        logic       ack;
        int         reps;
        logic       exp_valid;
        logic [3:0] exp_out;
        logic [3:0] exp_active;
        logic [7:0] exp_rej;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Confirm 1010 with ack held, then let active expire.
        tbl.push_back('{4'b1010, 1'b1, 1,  1'b0, 4'b0000, 4'b0000, 8'd0});
        tbl.push_back('{4'b0000, 1'b1, 4,  1'b0, 4'b0000, 4'b0000, 8'd0});
        tbl.push_back('{4'b1010, 1'b1, 1,  1'b1, 4'b1010, 4'b1010, 8'd0});
        tbl.push_back('{4'b0000, 1'b1, 19, 1'b0, 4'b1010, 4'b1010, 8'd0});
        tbl.push_back('{4'b0000, 1'b1, 1,  1'b0, 4'b1010, 4'b0000, 8'd0});
        // Lone 1000 times out after the window.
        tbl.push_back('{4'b1000, 1'b0, 1,  1'b0, 4'b1010, 4'b0000, 8'd0});
        tbl.push_back('{4'b0000, 1'b0, 9,  1'b0, 4'b1010, 4'b0000, 8'd0});
        tbl.push_back('{4'b0000, 1'b0, 1,  1'b0, 4'b1010, 4'b0000, 8'd1});
        // Candidate switch 0101 -> 0111 without a reject.
        tbl.push_back('{4'b0101, 1'b0, 1,  1'b0, 4'b1010, 4'b0000, 8'd1});
        tbl.push_back('{4'b0000, 1'b0, 2,  1'b0, 4'b1010, 4'b0000, 8'd1});
        tbl.push_back('{4'b0111, 1'b0, 1,  1'b0, 4'b1010, 4'b0000, 8'd1});
        tbl.push_back('{4'b0000, 1'b0, 2,  1'b0, 4'b1010, 4'b0000, 8'd1});
        tbl.push_back('{4'b0111, 1'b0, 1,  1'b1, 4'b0111, 4'b0111, 8'd1});
        tbl.push_back('{4'b0000, 1'b1, 1,  1'b0, 4'b0111, 4'b0111, 8'd1});

        step(1'b0, 1'b0, 4'd0, 1'b0);
        check("reset_state", {cmd_out, cmd_valid, active_cmd, overrun_count, reject_count}, 0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(1'b1, 1'b0, (r == 0) ? tbl[i].cmd : 4'd0, tbl[i].ack);
                check($sformatf("tbl%0d", i), {cmd_valid, cmd_out, active_cmd, reject_count},
                      {tbl[i].exp_valid, tbl[i].exp_out, tbl[i].exp_active, tbl[i].exp_rej});
            end
        end

        // Overrun while waiting for ack.
        step(1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'b1011, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b1011, 1'b0);
        check("confirm_1011", {cmd_valid, cmd_out}, {1'b1, 4'b1011});
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b1011, 1'b0);
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
        check("overrun_3", {cmd_valid, overrun_count}, {1'b1, 8'd3});
        step(1'b1, 1'b0, 4'b0101, 1'b1);
        check("ack_drop", {cmd_valid, cmd_out, overrun_count}, {1'b0, 4'b1011, 8'd4});
        step(1'b1, 1'b0, 4'd0, 1'b1);
        check("ack_idle_no_cand", {cmd_valid, overrun_count}, {1'b0, 8'd4});

        // Training mid-candidate flushes hits.
        step(1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0110, 1'b0);
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        check("train_no_confirm", cmd_valid, 1'b0);
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        check("train_restart", {cmd_valid, cmd_out}, {1'b1, 4'b0110});

        // Reset mid-handshake.
        step(1'b0, 1'b0, 4'd0, 1'b0);
        check("reset_mid_hs", {cmd_out, cmd_valid, active_cmd, overrun_count, reject_count}, 0);

        // Out-of-range codes never confirm.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'b0000, 1'b0);
            step(1'b1, 1'b0, 4'b1111, 1'b0);
            step(1'b1, 1'b0, 4'b0011, 1'b0);
            step(1'b1, 1'b0, 4'b1100, 1'b0);
        end
        check("invalid_codes", {cmd_valid, active_cmd, reject_count}, 0);

        // Overrun counter saturation.
        step(1'b1, 1'b0, 4'b1001, 1'b0);
        step(1'b1, 1'b0, 4'b1001, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 4'b0100, 1'b0);
        check("overrun_sat", overrun_count, 8'hFF);

        // Random run against the model.
        step(1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic       rst, tr, ack;
            logic [3:0] cmd;
            int         r;
            rst = ($urandom % 300) != 0;
            tr  = ($urandom % 120) == 0;
            ack = ($urandom % 4) == 0;
            r   = $urandom % 8;
            if (r < 5) cmd = 4'd0;
            else if (($urandom % 3) == 0) cmd = 4'($urandom % 16);
            else cmd = 4'd4 + 4'($urandom % 2);
            step(rst, tr, cmd, ack);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
